core_run_ctrl: RTL
==================

CORE_RUN_CTRL -- requirements
Module: core_run_ctrl

Interface
REQ-001 SHALL have parameter XLEN, 32, register/instruction width.
REQ-002 SHALL have parameter NUM_REGS, 32, register-file entries dumped and checked (>=2).
REQ-003 SHALL have parameter RESET_CYCLES, 2, core reset hold length in cycles (>=1).
REQ-004 SHALL have parameter MAX_CYCLES, 16, run budget in cycles before timeout (>=1).
REQ-005 SHALL have parameter HALT_INSN, 32'h0000006F, instruction word (jal x0,0) signalling program end.
REQ-006 SHALL have parameter CHECK_MASK, all ones [NUM_REGS-1:0], bit i set = register i compared.
REQ-007 SHALL have ports: clk in 1 clock; rst in 1 reset (one clock; reset is synchronous and active-high).
REQ-008 SHALL have ports: start in 1 begin run; instr_i in XLEN instruction currently fetched by core.
REQ-009 SHALL have ports: core_rst_o out 1 core reset; core_run_o out 1 core clock-enable.
REQ-010 SHALL have ports: rf_addr_o out $clog2(NUM_REGS) dump address; rf_rd_o out 1 dump read strobe; rf_data_i in XLEN read data; exp_data_i in XLEN expected value for the same address.
REQ-011 SHALL have ports: busy out 1; done out 1; pass out 1; timeout out 1; mismatch_cnt out $clog2(NUM_REGS+1); first_bad_reg out $clog2(NUM_REGS); cycle_cnt out $clog2(MAX_CYCLES+1).

Function
REQ-012 SHALL implement FSM states IDLE, HOLD_RST, RUN, DUMP, DONE.
REQ-013 IDLE: core_rst_o=1, core_run_o=0, busy=0; start=1 -> HOLD_RST, clearing cycle_cnt, mismatch_cnt, first_bad_reg, timeout, pass, done.
REQ-014 HOLD_RST: core_rst_o=1 for exactly RESET_CYCLES cycles, busy=1, then -> RUN.
REQ-015 RUN: core_rst_o=0, core_run_o=1; cycle_cnt increments by 1 each RUN cycle, first RUN cycle counts as 1.
REQ-016 RUN: instr_i==HALT_INSN -> DUMP next cycle, timeout stays 0; that cycle is counted.
REQ-017 RUN: cycle_cnt reaching MAX_CYCLES without halt -> timeout=1, DUMP next cycle; halt in the same cycle wins (timeout=0).
REQ-018 DUMP: core_run_o=0, core_rst_o=0 (core frozen, state preserved); rf_rd_o=1 while rf_addr_o steps 0..NUM_REGS-1, one address per cycle.
REQ-019 Read latency exactly 1 cycle: rf_data_i/exp_data_i sampled the cycle after the address; state leaves DUMP one cycle after last address (NUM_REGS+1 cycles in DUMP).
REQ-020 Per sample with CHECK_MASK[i]=1 and rf_data_i!=exp_data_i: mismatch_cnt+=1; first_bad_reg latched to i on first mismatch only; masked registers never counted.
REQ-021 DONE: done=1, busy=0, pass=(mismatch_cnt==0 && !timeout), core_rst_o=0, core_run_o=0; results held until start.
REQ-022 start in DONE behaves as in IDLE (new run); start ignored in HOLD_RST, RUN, DUMP.
REQ-023 first_bad_reg SHALL read 0 when mismatch_cnt==0; cycle_cnt holds final value after RUN.
REQ-024 All outputs registered except rf_addr_o/rf_rd_o, which may be state-decoded.

Reset
REQ-025 rst=1 at any clock edge, any state (incl. mid-RUN/mid-DUMP) -> IDLE next cycle: core_rst_o=1, core_run_o=0, rf_rd_o=0, rf_addr_o=0, busy/done/pass/timeout=0, all counters 0.
REQ-026 rst has priority over start in the same cycle.

Verification
REQ-027 Defaults, start pulse, HALT_INSN at 4th RUN cycle, rf==exp -> core_rst_o high 2 cycles, cycle_cnt=4, done=1, pass=1, mismatch_cnt=0.
REQ-028 MAX_CYCLES=16, instr never HALT_INSN -> exactly 16 RUN cycles, timeout=1, pass=0, DUMP still performed.
REQ-029 rf[3]=5 vs exp 6, rf[7]=0 vs exp 1 -> mismatch_cnt=2, first_bad_reg=3, pass=0.
REQ-030 CHECK_MASK bit 3 cleared, same data as REQ-029 -> mismatch_cnt=1, first_bad_reg=7.
REQ-031 HALT_INSN on the cycle cycle_cnt reaches 16 -> timeout=0, cycle_cnt=16.
REQ-032 rst asserted during DUMP at address 10 -> next cycle IDLE, all outputs at reset values; subsequent start runs cleanly.

Source files
------------

// File: rtl/core_run_ctrl.sv
// Run controller for a core under test: holds it in reset, lets it run until
// it halts or exhausts its cycle budget, then dumps and checks its register file.
module core_run_ctrl #(
    parameter int                   XLEN         = 32,
    parameter int                   NUM_REGS     = 32,
    parameter int                   RESET_CYCLES = 2,
    parameter int                   MAX_CYCLES   = 16,
    parameter logic [XLEN-1:0]      HALT_INSN    = 32'h0000006F,
    parameter logic [NUM_REGS-1:0]  CHECK_MASK   = '1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic [XLEN-1:0]                   instr_i,
    output logic                              core_rst_o,
    output logic                              core_run_o,
    output logic [$clog2(NUM_REGS)-1:0]       rf_addr_o,
    output logic                              rf_rd_o,
    input  logic [XLEN-1:0]                   rf_data_i,
    input  logic [XLEN-1:0]                   exp_data_i,
    output logic                              busy,
    output logic                              done,
    output logic                              pass,
    output logic                              timeout,
    output logic [$clog2(NUM_REGS+1)-1:0]     mismatch_cnt,
    output logic [$clog2(NUM_REGS)-1:0]       first_bad_reg,
    output logic [$clog2(MAX_CYCLES+1)-1:0]   cycle_cnt
);

    localparam int AW = $clog2(NUM_REGS);
    localparam int MW = $clog2(NUM_REGS + 1);
    localparam int CW = $clog2(MAX_CYCLES + 1);
    localparam int HW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

    typedef enum logic [2:0] {IDLE, HOLD_RST, RUN, DUMP, DONE} state_t;

    state_t          state_q;
    logic            coreRst_q, coreRun_q, busy_q, done_q, pass_q, timeout_q;
    logic [MW-1:0]   mismatchCnt_q, mismatchCnt_d;
    logic [AW-1:0]   firstBad_q;
    logic [CW-1:0]   cycleCnt_q, cycleCnt_d;
    logic [HW-1:0]   holdCnt_q;
    logic [MW-1:0]   dumpCnt_q;
    logic [MW-1:0]   prevIdx;
    logic [AW-1:0]   sampleIdx;
    logic            sampleBad;

    // Data returned in a DUMP cycle belongs to the address issued one cycle earlier.
    assign prevIdx       = dumpCnt_q - MW'(1);
    assign sampleIdx     = prevIdx[AW-1:0];
    assign sampleBad     = (state_q == DUMP) && (dumpCnt_q != '0) &&
                           CHECK_MASK[sampleIdx] && (rf_data_i != exp_data_i);
    assign mismatchCnt_d = mismatchCnt_q + MW'(sampleBad);
    assign cycleCnt_d    = cycleCnt_q + CW'(1);

    assign rf_rd_o   = (state_q == DUMP) && (dumpCnt_q < MW'(NUM_REGS));
    assign rf_addr_o = rf_rd_o ? dumpCnt_q[AW-1:0] : '0;

    assign core_rst_o    = coreRst_q;
    assign core_run_o    = coreRun_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign timeout       = timeout_q;
    assign mismatch_cnt  = mismatchCnt_q;
    assign first_bad_reg = firstBad_q;
    assign cycle_cnt     = cycleCnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            coreRst_q     <= 1'b1;
            coreRun_q     <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
            timeout_q     <= 1'b0;
            mismatchCnt_q <= '0;
            firstBad_q    <= '0;
            cycleCnt_q    <= '0;
            holdCnt_q     <= '0;
            dumpCnt_q     <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q       <= HOLD_RST;
                        coreRst_q     <= 1'b1;
                        coreRun_q     <= 1'b0;
                        busy_q        <= 1'b1;
                        done_q        <= 1'b0;
                        pass_q        <= 1'b0;
                        timeout_q     <= 1'b0;
                        mismatchCnt_q <= '0;
                        firstBad_q    <= '0;
                        cycleCnt_q    <= '0;
                        holdCnt_q     <= '0;
                    end
                end
                HOLD_RST: begin
                    if (holdCnt_q == HW'(RESET_CYCLES - 1)) begin
                        state_q   <= RUN;
                        coreRst_q <= 1'b0;
                        coreRun_q <= 1'b1;
                    end else begin
                        holdCnt_q <= holdCnt_q + HW'(1);
                    end
                end
                RUN: begin
                    // A halt seen on the budget's last cycle is a clean finish, not a timeout.
                    cycleCnt_q <= cycleCnt_d;
                    if (instr_i == HALT_INSN) begin
                        state_q   <= DUMP;
                        coreRun_q <= 1'b0;
                        dumpCnt_q <= '0;
                    end else if (cycleCnt_d == CW'(MAX_CYCLES)) begin
                        state_q   <= DUMP;
                        coreRun_q <= 1'b0;
                        timeout_q <= 1'b1;
                        dumpCnt_q <= '0;
                    end
                end
                DUMP: begin
                    mismatchCnt_q <= mismatchCnt_d;
                    if (sampleBad && (mismatchCnt_q == '0))
                        firstBad_q <= sampleIdx;
                    if (dumpCnt_q == MW'(NUM_REGS)) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (mismatchCnt_d == '0) && !timeout_q;
                    end else begin
                        dumpCnt_q <= dumpCnt_q + MW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
